// File: rtl/pc_bp_pkg.sv
// Shared widths and direction-counter helpers for the fetch PC / BTB slice.
package pc_bp_pkg;

    localparam int IMEM_ADDR_W = 10;

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int ctr_max(input int w);
        return (1 << w) - 1;
    endfunction

    function automatic int ctr_inc(input int c, input int w);
        return (c >= ctr_max(w)) ? ctr_max(w) : c + 1;
    endfunction

    function automatic int ctr_dec(input int c);
        return (c == 0) ? 0 : c - 1;
    endfunction

    function automatic int ctr_weak_taken(input int w);
        return 1 << (w - 1);
    endfunction

    function automatic int ctr_weak_nt(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/syn_pc_bp_btb.sv
// Direct-mapped BTB: combinational tag-checked lookup, synchronous allocate/saturate update.
module syn_btb
    import pc_bp_pkg::*;
#(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int BTB_DEPTH = 16,
    parameter int CTR_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lk_pc,
    output logic              lk_hit,
    output logic              lk_taken,
    output logic [ADDR_W-1:0] lk_target,
    input  logic              upd_en,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target
);
    localparam int IDX_W = idx_w(BTB_DEPTH);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(ctr_weak_taken(CTR_W));
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(ctr_weak_nt(CTR_W));

    logic [BTB_DEPTH-1:0]             valid_q, valid_d;
    logic [BTB_DEPTH-1:0][CTR_W-1:0]  ctr_q, ctr_d;
    logic [BTB_DEPTH-1:0][TAG_W-1:0]  tag_q, tag_d;
    logic [BTB_DEPTH-1:0][ADDR_W-1:0] tgt_q, tgt_d;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             up_hit;

    assign lk_idx    = lk_pc[IDX_W-1:0];
    assign lk_tag    = lk_pc[ADDR_W-1:IDX_W];
    assign lk_hit    = valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
    assign lk_taken  = lk_hit & ctr_q[lk_idx][CTR_W-1];
    assign lk_target = tgt_q[lk_idx];

    assign up_idx = upd_pc[IDX_W-1:0];
    assign up_tag = upd_pc[ADDR_W-1:IDX_W];
    assign up_hit = valid_q[up_idx] & (tag_q[up_idx] == up_tag);

    always_comb begin
        valid_d = valid_q;
        ctr_d   = ctr_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        if (upd_en) begin
            if (up_hit) begin
                ctr_d[up_idx] = upd_taken ? CTR_W'(ctr_inc(int'(ctr_q[up_idx]), CTR_W))
                                          : CTR_W'(ctr_dec(int'(ctr_q[up_idx])));
                if (upd_taken) tgt_d[up_idx] = upd_target;
            end else if (upd_taken) begin
                // Miss on a taken branch claims the slot, evicting any alias.
                valid_d[up_idx] = 1'b1;
                tag_d[up_idx]   = up_tag;
                tgt_d[up_idx]   = upd_target;
                ctr_d[up_idx]   = CTR_WT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            ctr_q   <= {BTB_DEPTH{CTR_WNT}};
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end

    // Tags/targets are only meaningful behind a valid bit, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
    end

endmodule

// File: rtl/syn_pc_bp.sv
// Fetch program counter with BTB prediction, mispredict redirect and saturating perf counters.
module syn_pc_bp
    import pc_bp_pkg::*;
#(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int BTB_DEPTH = 16,
    parameter int CTR_W     = 2,
    parameter int RESET_PC  = 0,
    parameter int PERF_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              stall,
    input  logic              res_valid,
    input  logic [ADDR_W-1:0] res_pc,
    input  logic              res_taken,
    input  logic [ADDR_W-1:0] res_target,
    input  logic              res_mispredict,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_4,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    output logic              flush,
    output logic [PERF_W-1:0] perf_res,
    output logic [PERF_W-1:0] perf_miss
);
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PERF_W-1:0] perf_res_q, perf_res_d, perf_miss_q, perf_miss_d;
    logic              res_acc;
    logic              bt_hit;
    logic [ADDR_W-1:0] bt_target;

    syn_btb #(
        .ADDR_W   (ADDR_W),
        .BTB_DEPTH(BTB_DEPTH),
        .CTR_W    (CTR_W)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .lk_pc     (pc_q),
        .lk_hit    (bt_hit),
        .lk_taken  (pred_taken),
        .lk_target (bt_target),
        .upd_en    (res_acc),
        .upd_pc    (res_pc),
        .upd_taken (res_taken),
        .upd_target(res_target)
    );

    assign res_acc     = en & res_valid;
    assign flush       = res_acc & res_mispredict;
    assign pc          = pc_q;
    assign pc_4        = pc_q + ADDR_W'(1);
    assign pred_target = bt_hit ? bt_target : pc_4;
    assign perf_res    = perf_res_q;
    assign perf_miss   = perf_miss_q;

    always_comb begin
        pc_d = pc_q;
        if (!en)        pc_d = pc_q;
        else if (flush) pc_d = res_taken ? res_target : res_pc + ADDR_W'(1);
        else if (stall) pc_d = pc_q;
        else            pc_d = pred_taken ? pred_target : pc_4;
    end

    always_comb begin
        perf_res_d  = perf_res_q;
        perf_miss_d = perf_miss_q;
        if (res_acc && perf_res_q != '1) perf_res_d = perf_res_q + PERF_W'(1);
        if (flush && perf_miss_q != '1)  perf_miss_d = perf_miss_q + PERF_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= ADDR_W'(RESET_PC);
            perf_res_q  <= '0;
            perf_miss_q <= '0;
        end else begin
            pc_q        <= pc_d;
            perf_res_q  <= perf_res_d;
            perf_miss_q <= perf_miss_d;
        end
    end

endmodule

// File: doc/syn_pc_bp.md
# syn_pc_bp

Parametrised synchronous program counter with an integrated direct-mapped branch target buffer (BTB) and per-entry saturating direction counters. It generalises the single-entry guess/commit PC: prediction depth, counter width, address width and reset vector are parameters. It adds tag-checked lookup, allocate-on-taken, and counter hysteresis, plus saturating performance counters. It sits at the head of the fetch stage, drives the instruction-memory word address, and takes branch/jump resolutions back from execute.

## Interface
- ADDR_W, 10: instruction word-address width; must be greater than log2(BTB_DEPTH).
- BTB_DEPTH, 16: BTB entries; power of two, at least 2. IDX_W = log2(BTB_DEPTH), TAG_W = ADDR_W-IDX_W.
- CTR_W, 2: direction counter width, at least 1.
- RESET_PC, 0: PC value after reset.
- PERF_W, 16: performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable; low freezes all state.
- stall  in  1  hold PC (pipeline hazard).
- res_valid  in  1  a branch/jump resolved this cycle.
- res_pc  in  ADDR_W  address of the resolved instruction.
- res_taken  in  1  actual direction.
- res_target  in  ADDR_W  actual taken target.
- res_mispredict  in  1  the fetched successor was wrong; qualified by res_valid.
- pc  out  ADDR_W  current fetch address (registered).
- pc_4  out  ADDR_W  pc+1 modulo 2^ADDR_W.
- pred_taken  out  1  BTB hit and counter MSB set.
- pred_target  out  ADDR_W  BTB target on hit, else pc_4.
- flush  out  1  combinational: en & res_valid & res_mispredict.
- perf_res  out  PERF_W  count of accepted resolutions.
- perf_miss  out  PERF_W  count of accepted mispredicts.

## Operation
- Lookup is combinational from pc. idx = pc[IDX_W-1:0] and tag = pc[ADDR_W-1:IDX_W]. hit = valid[idx] & (tag_mem[idx]==tag). pred_taken = hit & ctr[idx][CTR_W-1].
- next_pc priority: rst > !en (hold) > flush (res_taken ? res_target : res_pc+1, wrapping) > stall (hold) > pred_taken ? pred_target : pc_4.
- BTB update requires en & res_valid. Indexing uses res_pc.
  - On a hit, the counter saturates: increment toward all-ones if taken, decrement toward 0 if not. If taken, target is rewritten with res_target.
  - On a miss with res_taken=1, the entry is allocated or overwrites the alias: valid=1, tag, target, counter = 1<<(CTR_W-1) (weakly taken).
  - On a miss with res_taken=0, nothing changes.
- BTB updates are independent of stall.
- Same-cycle lookup and update of one index: the lookup sees the pre-update contents. The update is visible the next cycle.
- Perf counters increment on the same qualification as BTB updates. perf_miss also requires res_mispredict. Both saturate at all-ones and never wrap.
- Reset clears, asynchronously:
  - pc=RESET_PC.
  - Every valid bit to 0 and every counter to 1<<(CTR_W-1)-1 (weakly not-taken). Targets and tags are don't-care.
  - perf_res=perf_miss=0.
  - Resulting outputs: pc_4=RESET_PC+1, pred_taken=0, pred_target=pc_4, flush=en&res_valid&res_mispredict.
- Reset asserted mid-operation overrides any pending update or redirect in that cycle.

## Timing
- pc changes only on a rising clk edge, or asynchronously on reset.
- Prediction has zero cycles of latency: pred_* is valid in the cycle pc is presented.
- Redirect penalty is one cycle. A flush in cycle N puts the corrected pc on the outputs in cycle N+1, regardless of stall.
- A BTB write in cycle N affects the lookup in cycle N+1 onward.
- No handshake on the resolution bus. Each res_valid cycle is one event. The producer guarantees at most one per cycle.

## Structure
- Shared package pc_bp_pkg holds:
  - the width function for IDX_W;
  - the counter helper functions (saturating inc/dec, weak-taken/weak-not-taken constants);
  - the existing instruction-memory address-width constant, as the default for ADDR_W.
- One sub-module, syn_btb:
  - valid/tag/target/counter arrays;
  - combinational lookup port;
  - synchronous update port with the allocate and saturate rules.
- syn_pc_bp keeps the PC register, next-PC priority mux, flush and perf counters.

## Test plan
- Reset and sequential fetch: ADDR_W=4, rst pulse, no resolutions. pc = 0,1,…,15,0 (wrap), pred_taken=0 throughout.
- Allocate then predict: resolve res_pc=3, taken, target=9, no mispredict. After pc reaches 3 again, pred_taken=1 and the next pc is 9.
- Hysteresis with CTR_W=2:
  - from weakly taken, one not-taken resolution gives counter 01 and pred_taken=0;
  - two taken resolutions give 11;
  - one not-taken gives 10 and pred_taken=1.
- Alias with BTB_DEPTH=4: entry for pc=1 allocated. Lookup at pc=5 misses (tag mismatch) with pred_taken=0. A taken resolution at 5 evicts 1.
- Priority:
  - stall=1 and flush with res_taken=0, res_pc=7 in the same cycle gives pc=8 next cycle;
  - en=0 with res_valid=1 changes neither pc, the BTB, nor the perf counters.
- Perf counters and mid-operation reset: PERF_W=2 with 5 mispredicts gives perf_miss=3, held. rst asserted mid-cycle forces pc=RESET_PC immediately and clears both perf counters.
